// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Used by if_fifo and if_fetch_unit.
package if_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_entry_t;

  // Byte PC to memory word address.
  function automatic logic [XLEN-1:0] pc_to_word(input logic [XLEN-1:0] pc);
    return {2'b00, pc[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small circular FIFO of tagged fetch entries; flush wins over push.
// The head entry is presented from registers so the output is glitch-free.
module if_fifo
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  if_entry_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output if_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  if_entry_t        mem_q [DEPTH];
  if_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, single outstanding memory read, tagged output FIFO.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_squashed counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             pop, push, issue;
  logic [CNT_W:0]   occ;
  if_entry_t        push_data, head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign mem_addr  = pc_to_word(fetch_pc_q);

  // Slots already promised (buffered + in flight) minus the one leaving now.
  always_comb begin
    occ   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    issue = !redirect_valid && (occ < (CNT_W + 1)'(DEPTH));
  end

  always_comb begin
    push           = inflight_q && (!fifo_full || pop);
    push_data.pc    = inflight_pc_q;
    push_data.instr = mem_dout;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      inflight_pc_d = fetch_pc_q;
      inflight_d    = 1'b1;
      fetch_pc_d    = fetch_pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  // Redirect flushes the FIFO; the in-flight response is dropped by clearing inflight.
  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] squashed_q, squashed_d;

  always_comb begin
    fetched_d  = fetched_q;
    squashed_d = squashed_q;
    if (pop) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (redirect_valid) begin
      squashed_d = squashed_q + 32'(fifo_count) + {31'b0, inflight_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: two instances (DEPTH=2 at PC 0, DEPTH=3 at PC FFFFFFFC)
// checked against an in-order PC-stream reference model; perf counters checked when IF_PERF_CNT_EN is set.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] mem_addr_a, mem_dout_a, out_pc_a, out_instr_a, redirect_pc_a;
  logic        out_valid_a, out_ready_a, redirect_valid_a;
  logic [31:0] mem_addr_b, mem_dout_b, out_pc_b, out_instr_b, redirect_pc_b;
  logic        out_valid_b, out_ready_b, redirect_valid_b;
`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_a, ps_a, pf_b, ps_b;
  logic [31:0] s_pf [2];
  logic [31:0] s_ps [2];
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pc(out_pc_a), .out_instr(out_instr_a),
    .redirect_valid(redirect_valid_a), .redirect_pc(redirect_pc_a)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(pf_a), .perf_squashed(ps_a)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b), .out_instr(out_instr_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(pf_b), .perf_squashed(ps_b)
`endif
  );

  // Synchronous one-cycle-latency instruction memories with a computable pattern.
  always @(posedge clk) mem_dout_a <= 32'hA000_0001 + mem_addr_a;
  always @(posedge clk) mem_dout_b <= 32'hA000_0001 + mem_addr_b;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc [2];
  int          hs_total [2];
  logic        prev_hold [2];
  logic [31:0] prev_pc [2];
  logic [31:0] prev_instr [2];
  logic        s_valid [2];
  logic [31:0] s_pc [2];
  logic [31:0] s_instr [2];
  logic [31:0] s_addr [2];
  int          hs_rand [2];

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'hA000_0001 + (pc >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: output is the in-order stream exp_pc, exp_pc+4, ... restarted at each redirect target.
  task automatic model(input int k, input logic rdy, input logic rv, input logic [31:0] rpc);
    string n;
    n = (k == 0) ? "a" : "b";
    if (!rst_n) return;
`ifdef IF_PERF_CNT_EN
    chk({"perf_fetched_", n}, s_pf[k], 32'(hs_total[k]));
`endif
    if (prev_hold[k]) begin
      chk({"hold_valid_", n}, {31'b0, s_valid[k]}, 32'd1);
      chk({"hold_pc_", n}, s_pc[k], prev_pc[k]);
      chk({"hold_instr_", n}, s_instr[k], prev_instr[k]);
    end
    if (s_valid[k] && rdy) begin
      chk({"stream_pc_", n}, s_pc[k], exp_pc[k]);
      chk({"stream_instr_", n}, s_instr[k], word_of(exp_pc[k]));
      exp_pc[k] = exp_pc[k] + 32'd4;
      hs_total[k]++;
      hs_rand[k]++;
    end
    if (rv) exp_pc[k] = rpc & ~32'h3;
    prev_hold[k]  = s_valid[k] && !rdy && !rv;
    prev_pc[k]    = s_pc[k];
    prev_instr[k] = s_instr[k];
  endtask

  // One clock cycle: inputs were set at posedge+1; sample at negedge; return at next posedge+1.
  task automatic cyc();
    @(negedge clk);
    s_valid[0] = out_valid_a; s_pc[0] = out_pc_a; s_instr[0] = out_instr_a; s_addr[0] = mem_addr_a;
    s_valid[1] = out_valid_b; s_pc[1] = out_pc_b; s_instr[1] = out_instr_b; s_addr[1] = mem_addr_b;
`ifdef IF_PERF_CNT_EN
    s_pf[0] = pf_a; s_ps[0] = ps_a; s_pf[1] = pf_b; s_ps[1] = ps_b;
`endif
    model(0, out_ready_a, redirect_valid_a, redirect_pc_a);
    model(1, out_ready_b, redirect_valid_b, redirect_pc_b);
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one cycle, then release at the start of cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    out_ready_a = 1'b1; redirect_valid_a = 1'b0; redirect_pc_a = '0;
    out_ready_b = 1'b1; redirect_valid_b = 1'b0; redirect_pc_b = '0;
    exp_pc[0] = 32'h0000_0000;
    exp_pc[1] = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      hs_total[k] = 0;
      prev_hold[k] = 1'b0;
    end
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready_a = 1'b1; redirect_valid_a = 1'b0; redirect_pc_a = '0;
    out_ready_b = 1'b1; redirect_valid_b = 1'b0; redirect_pc_b = '0;
    hs_rand[0] = 0; hs_rand[1] = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_valid_a", {31'b0, s_valid[0]}, 32'd0);
    chk("rst_pc_a", s_pc[0], 32'd0);
    chk("rst_instr_a", s_instr[0], 32'd0);
    chk("rst_addr_a", s_addr[0], 32'd0);
    chk("rst_valid_b", {31'b0, s_valid[1]}, 32'd0);
    chk("rst_addr_b", s_addr[1], 32'h3FFF_FFFF);

    // Latency and full-rate streaming.
    cyc(); chk("lat_c0_valid_a", {31'b0, s_valid[0]}, 32'd0);
    cyc(); chk("lat_c1_valid_a", {31'b0, s_valid[0]}, 32'd0);
    chk("lat_c1_valid_b", {31'b0, s_valid[1]}, 32'd0);
    cyc(); chk("lat_c2_valid_a", {31'b0, s_valid[0]}, 32'd1);
    chk("lat_c2_pc_a", s_pc[0], 32'h0);
    chk("lat_c2_instr_a", s_instr[0], 32'hA000_0001);
    chk("wrap_c2_pc_b", s_pc[1], 32'hFFFF_FFFC);
    cyc(); chk("str_c3_pc_a", s_pc[0], 32'h4);
    chk("str_c3_instr_a", s_instr[0], 32'hA000_0002);
    chk("wrap_c3_pc_b", s_pc[1], 32'h0);
    cyc(); chk("str_c4_pc_a", s_pc[0], 32'h8);
    chk("str_c4_instr_a", s_instr[0], 32'hA000_0003);
    cyc(); chk("str_c5_pc_a", s_pc[0], 32'hC);
    chk("str_c5_instr_a", s_instr[0], 32'hA000_0004);

    // Stall: FIFO fills, fetch address freezes, head is held.
    out_ready_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_valid_a", {31'b0, s_valid[0]}, 32'd1);
      chk("stall_pc_a", s_pc[0], 32'h10);
      chk("stall_addr_a", s_addr[0], 32'h6);
    end
    out_ready_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("resume_valid_a", {31'b0, s_valid[0]}, 32'd1);
    end

    // Redirect while the FIFO is full.
    out_ready_a = 1'b0;
    cyc(); cyc(); cyc();
    redirect_valid_a = 1'b1; redirect_pc_a = 32'h40;
    cyc();
    redirect_valid_a = 1'b0; out_ready_a = 1'b1;
    cyc(); chk("redir_n1_valid_a", {31'b0, s_valid[0]}, 32'd0);
    cyc(); chk("redir_n2_valid_a", {31'b0, s_valid[0]}, 32'd0);
    cyc(); chk("redir_n3_valid_a", {31'b0, s_valid[0]}, 32'd1);
    chk("redir_n3_pc_a", s_pc[0], 32'h40);
    cyc(); chk("redir_n4_pc_a", s_pc[0], 32'h44);

    // Misaligned target is forced to a word boundary.
    redirect_valid_a = 1'b1; redirect_pc_a = 32'h43;
    cyc();
    redirect_valid_a = 1'b0;
    cyc(); cyc(); cyc();
    chk("misal_valid_a", {31'b0, s_valid[0]}, 32'd1);
    chk("misal_pc_a", s_pc[0], 32'h40);

    // Back-to-back redirects: only the second target's stream appears.
    redirect_valid_a = 1'b1; redirect_pc_a = 32'h20;
    cyc();
    redirect_pc_a = 32'h80;
    cyc();
    chk("b2b_n1_valid_a", {31'b0, s_valid[0]}, 32'd0);
    redirect_valid_a = 1'b0;
    cyc(); chk("b2b_n2_valid_a", {31'b0, s_valid[0]}, 32'd0);
    cyc(); chk("b2b_n3_valid_a", {31'b0, s_valid[0]}, 32'd0);
    cyc(); chk("b2b_n4_pc_a", s_pc[0], 32'h80);
    cyc(); chk("b2b_n5_pc_a", s_pc[0], 32'h84);

    // Asynchronous reset mid-stream.
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid_a", {31'b0, out_valid_a}, 32'd0);
    chk("async_pc_a", out_pc_a, 32'd0);
    chk("async_valid_b", {31'b0, out_valid_b}, 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    cyc(); cyc(); cyc();
    chk("restart_pc_a", s_pc[0], 32'h0);
    chk("restart_pc_b", s_pc[1], 32'hFFFF_FFFC);
    cyc(); cyc(); cyc(); cyc();
    // B: one stall cycle leaves 2 buffered + 1 in flight, then squash them.
    out_ready_b = 1'b0;
    cyc();
    redirect_valid_b = 1'b1; redirect_pc_b = 32'h100;
    cyc();
    redirect_valid_b = 1'b0; out_ready_b = 1'b1;
    cyc();
    chk("squash_valid_b", {31'b0, s_valid[1]}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched_b5", s_pf[1], 32'd5);
    chk("perf_squashed_b3", s_ps[1], 32'd3);
    chk("perf_fetched_a7", s_pf[0], 32'd7);
    chk("perf_squashed_a0", s_ps[0], 32'd0);
`endif
    cyc(); cyc();
    chk("squash_target_b", s_pc[1], 32'h100);

    // Randomized ready/redirect traffic on both instances.
    hs_rand[0] = 0; hs_rand[1] = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready_a      = ($urandom_range(0, 3) != 0);
      redirect_valid_a = ($urandom_range(0, 15) == 0);
      redirect_pc_a    = $urandom;
      out_ready_b      = ($urandom_range(0, 2) != 0);
      redirect_valid_b = ($urandom_range(0, 19) == 0);
      redirect_pc_b    = $urandom;
      cyc();
    end
    out_ready_a = 1'b1; redirect_valid_a = 1'b0;
    out_ready_b = 1'b1; redirect_valid_b = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("progress_a", {31'b0, (hs_rand[0] > 100)}, 32'd1);
    chk("progress_b", {31'b0, (hs_rand[1] > 100)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the synchronous instruction memory (one-cycle read latency).
- Holds the PC and drives the memory word address.
- Tags each returning word with its PC and buffers it in a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake, and supports stall and branch redirect with squash of in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.
- DEPTH, 2, output FIFO entries; legal range 2..4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  out  32  word address to instruction memory = {2'b00, fetch_pc[31:2]}
- mem_dout  in  32  instruction word; valid one cycle after the address is sampled
- out_valid  out  1  {out_pc, out_instr} is valid
- out_ready  in  1  decode accepts this cycle
- out_pc  out  32  byte PC of the presented instruction
- out_instr  out  32  presented instruction
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  target byte address; bits [1:0] are ignored and forced to 0

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (async, any time): fetch_pc=RESET_PC, inflight=0, FIFO empty, out_valid=0, out_pc=0, out_instr=0.
- mem_addr is a combinational function of fetch_pc only.
- Issue rule: issue = !redirect_valid && (count + inflight − pop) < DEPTH, where pop = out_valid && out_ready.
  - On issue: at the clock edge, inflight_pc <= fetch_pc, inflight <= 1, fetch_pc <= fetch_pc + 4.
  - On non-issue: inflight <= 0 and fetch_pc holds. The memory still reads, but its result is ignored.
- Response: while inflight=1, mem_dout pairs with inflight_pc and is pushed into the FIFO at the next edge.
- Output: out_* come from the FIFO head registers. out_valid = !empty. Contents are held stable while out_valid && !out_ready.
- Latency:
  - First out_valid is in the third cycle after reset deasserts: cycle 0 issue, cycle 1 data, cycle 2 out_valid.
  - With out_ready held at 1, throughput is one instruction per cycle.
- Stall: out_ready=0 fills the FIFO. Issue stops so that no response is ever dropped. There is no overflow.
- Redirect (redirect_valid=1, cycle N):
  - A handshake in cycle N completes normally.
  - At the edge ending cycle N: FIFO flushed, inflight cleared (the response arriving in cycle N+1 is discarded), fetch_pc <= {redirect_pc[31:2], 2'b00}. No issue in cycle N.
  - Target is issued in cycle N+1, and out_valid=1 with out_pc = target in cycle N+3.
  - Back-to-back redirects: the last one wins.
- PC wrap: fetch_pc + 4 wraps modulo 2^32 silently.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_fetched[31:0] (increments on each out_valid && out_ready) and perf_squashed[31:0] (increments by the number of FIFO entries plus the in-flight entry discarded per redirect).
  - Both counters reset to 0 and wrap.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - XLEN=32 and INSTR_BYTES=4.
  - Typedef if_entry_t (struct {pc, instr}).
  - Function pc_to_word(pc).
- Sub-module if_fifo: parameterised DEPTH FIFO of if_entry_t with push, pop, flush (flush has priority over push), count, empty and full.
- if_fetch_unit instantiates if_fifo and owns the PC/inflight logic.

Test Plan:
- Reset release, memory preloaded A0000001..A0000004, out_ready=1 -> out_valid first high in cycle 2; (pc, instr) = (0,A0000001), (4,A0000002), (8,A0000003), (C,A0000004), one per cycle.
- out_ready=0 for 10 cycles after the first valid -> FIFO holds 2 entries, mem_addr frozen, out_* stable; on release, stream resumes at pc=0 with no gap, duplicate or loss.
- redirect_valid with redirect_pc=0x40 while the FIFO is full and a fetch is in flight -> no stale word emitted; 3 cycles later out_pc=0x40, then 0x44.
- redirect_pc=0x43 -> fetch begins at 0x40; back-to-back redirects to 0x20 then 0x80 -> only 0x80 stream appears.
- RESET_PC=32'hFFFF_FFFC -> out_pc sequence FFFFFFFC, 00000000 (wrap); async rst_n pulse mid-stream -> out_valid drops immediately and the stream restarts at RESET_PC.
- With IF_PERF_CNT_EN: 5 accepts, then a redirect with 2 buffered and 1 in flight -> perf_fetched=5, perf_squashed=3.
